// File: rtl/layernorm_pkg.sv
// -----------------------------------------------------------------------------
// layernorm_pkg
// Shared definitions for the LayerNorm statistics block and the downstream
// normalizer: FSM state encoding, element and output widths, and a
// saturating subtract helper used for the variance.
// -----------------------------------------------------------------------------
package layernorm_pkg;

    // Element width: signed int16 taken from input_data[15:0]
    localparam int ELEM_W = 16;
    // Output widths handed to the normalizer
    localparam int MEAN_W = 16;
    localparam int VAR_W  = 32;

    // Row statistics FSM
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        HOLD  = 2'd2
    } ln_state_t;

    // Unsigned a - b clamped at zero, result truncated to VAR_W bits.
    // Operands are zero-extended to 64 bits by the caller so any row length
    // fits without loss.
    function automatic logic [VAR_W-1:0] sat_sub_var(input logic [63:0] a,
                                                     input logic [63:0] b);
        logic [63:0] diff;
        if (a < b) begin
            diff = 64'd0;
        end else begin
            diff = a - b;
        end
        return diff[VAR_W-1:0];
    endfunction

endpackage : layernorm_pkg

// File: rtl/layernorm_stats.sv
// -----------------------------------------------------------------------------
// layernorm_stats
// Accumulates one row of N = 2^LOG2_N signed int16 elements and produces the
// row mean and (population) variance consumed by the LayerNorm normalizer.
//
// Ports
//   clk          in   single clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   valid_in     in   input element valid
//   in_ready     out  block can accept an element (ACCUM only)
//   input_data   in   [15:0] signed element, [31:16] ignored
//   valid_out    out  row statistics valid (HOLD only)
//   out_ready    in   downstream accepts the statistics
//   out_mean     out  signed row mean, floor(sum / N)
//   out_var      out  unsigned variance, (sumsq / N) - mean^2 clamped at 0
//
// Flow: ACCUM collects N elements, CALC registers mean/var for one cycle,
// HOLD presents them until the output handshake, then the next row starts
// from cleared accumulators.
// -----------------------------------------------------------------------------
module layernorm_stats
    import layernorm_pkg::*;
#(
    parameter int LOG2_N = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    output logic                     in_ready,
    input  logic [31:0]              input_data,
    output logic                     valid_out,
    input  logic                     out_ready,
    output logic signed [MEAN_W-1:0] out_mean,
    output logic [VAR_W-1:0]         out_var
);

    // Accumulator widths chosen so a full row of worst-case int16 values
    // cannot overflow: |x| <= 2^15, x^2 <= 2^30, N terms add LOG2_N bits.
    localparam int SUM_W = ELEM_W + LOG2_N;
    localparam int SQ_W  = 2 * ELEM_W + LOG2_N;

    ln_state_t                 state_r;
    ln_state_t                 next_state_s;
    logic [LOG2_N-1:0]         cnt_r;
    logic signed [SUM_W-1:0]   sum_r;
    logic [SQ_W-1:0]           sumsq_r;
    logic signed [MEAN_W-1:0]  mean_r;
    logic [VAR_W-1:0]          var_r;

    logic                      accept_s;
    logic                      last_s;
    logic                      out_fire_s;
    logic signed [ELEM_W-1:0]  elem_s;
    logic signed [2*ELEM_W-1:0] elem_sq_s;
    logic signed [SUM_W-1:0]   sum_shift_s;
    logic signed [MEAN_W-1:0]  mean_s;
    logic signed [2*MEAN_W-1:0] mean_sq_s;
    logic [SQ_W-1:0]           sq_avg_s;
    logic [VAR_W-1:0]          var_s;
    logic                      unused_hi_s;

    // Upper half of the input word carries no information for this block
    assign unused_hi_s = ^input_data[31:16];

    assign elem_s     = input_data[ELEM_W-1:0];
    assign accept_s   = valid_in && (state_r == ACCUM);
    // Counter sits at all-ones while waiting for element N
    assign last_s     = accept_s && (&cnt_r);
    assign out_fire_s = (state_r == HOLD) && out_ready;

    // Square of the incoming element; always non-negative, fits 31 bits
    assign elem_sq_s = elem_s * elem_s;

    // Arithmetic shift gives floor toward minus infinity; the shifted value
    // always fits MEAN_W bits because the sum has exactly LOG2_N guard bits.
    assign sum_shift_s = sum_r >>> LOG2_N;
    assign mean_s      = sum_shift_s[MEAN_W-1:0];
    assign mean_sq_s   = mean_s * mean_s;
    assign sq_avg_s    = sumsq_r >> LOG2_N;
    assign var_s       = sat_sub_var(64'(sq_avg_s), 64'($unsigned(mean_sq_s)));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        next_state_s = state_r;
        in_ready     = 1'b0;
        valid_out    = 1'b0;
        case (state_r)
            ACCUM: begin
                in_ready = 1'b1;
                if (last_s) begin
                    next_state_s = CALC;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            CALC: begin
                next_state_s = HOLD;
            end
            HOLD: begin
                valid_out = 1'b1;
                if (out_ready) begin
                    next_state_s = ACCUM;
                end else begin
                    next_state_s = HOLD;
                end
            end
            default: begin
                next_state_s = ACCUM;
            end
        endcase
    end

    // Element counter and row accumulators; cleared when the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {LOG2_N{1'b0}};
            sum_r   <= {SUM_W{1'b0}};
            sumsq_r <= {SQ_W{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= cnt_r + {{(LOG2_N-1){1'b0}}, 1'b1};
            sum_r   <= sum_r + {{LOG2_N{elem_s[ELEM_W-1]}}, elem_s};
            sumsq_r <= sumsq_r + {{LOG2_N{1'b0}}, $unsigned(elem_sq_s)};
        end else if (out_fire_s) begin
            cnt_r   <= {LOG2_N{1'b0}};
            sum_r   <= {SUM_W{1'b0}};
            sumsq_r <= {SQ_W{1'b0}};
        end else begin
            cnt_r   <= cnt_r;
            sum_r   <= sum_r;
            sumsq_r <= sumsq_r;
        end
    end

    // Result registers: loaded at the end of CALC, frozen through HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_r <= {MEAN_W{1'b0}};
            var_r  <= {VAR_W{1'b0}};
        end else if (state_r == CALC) begin
            mean_r <= mean_s;
            var_r  <= var_s;
        end else begin
            mean_r <= mean_r;
            var_r  <= var_r;
        end
    end

    assign out_mean = mean_r;
    assign out_var  = var_r;

endmodule : layernorm_stats

// File: tb/tb_layernorm_stats.sv
// -----------------------------------------------------------------------------
// tb_layernorm_stats
// Directed bench: DUT a uses N=4 for the row scenarios, DUT b uses N=64 for
// the full-scale negative row. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_layernorm_stats;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        valid_a, ready_a, vout_a, oready_a;
    logic [31:0] data_a;
    logic [15:0] mean_a;
    logic [31:0] var_a;

    logic        valid_b, ready_b, vout_b, oready_b;
    logic [31:0] data_b;
    logic [15:0] mean_b;
    logic [31:0] var_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    layernorm_stats #(.LOG2_N(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_a), .in_ready(ready_a),
        .input_data(data_a), .valid_out(vout_a), .out_ready(oready_a),
        .out_mean(mean_a), .out_var(var_a)
    );

    layernorm_stats #(.LOG2_N(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_b), .in_ready(ready_b),
        .input_data(data_b), .valid_out(vout_b), .out_ready(oready_b),
        .out_mean(mean_b), .out_var(var_b)
    );

    // Present one element to dut_a at a negedge and return at the negedge
    // after the edge that accepted it. valid_a is left asserted.
    task automatic push_a(input logic [15:0] v);
        int guard = 0;
        valid_a = 1'b1;
        data_a  = {16'hA5A5, v};
        while (!ready_a && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!ready_a) begin
            errors++;
            $display("FAIL push_a_timeout: in_ready=%0b required 1", ready_a);
        end
        @(negedge clk);
    endtask

    task automatic push_b(input logic [15:0] v);
        int guard = 0;
        valid_b = 1'b1;
        data_b  = {16'h5A5A, v};
        while (!ready_b && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!ready_b) begin
            errors++;
            $display("FAIL push_b_timeout: in_ready=%0b required 1", ready_b);
        end
        @(negedge clk);
    endtask

    task automatic wait_out_a();
        int guard = 0;
        while (!vout_a && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (!vout_a) begin
            errors++;
            $display("FAIL wait_out_a_timeout: valid_out=%0b required 1", vout_a);
        end
    endtask

    // Complete the output handshake on dut_a (one cycle of out_ready)
    task automatic handshake_a();
        oready_a = 1'b1;
        @(negedge clk);
        oready_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (vout_a !== 1'b0 || mean_a !== 16'h0000 || var_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid_out=%0b mean=%h var=%0d required 0/0000/0",
                     vout_a, mean_a, var_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1 || vout_a !== 1'b0 || ready_b !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b/%0b valid_out=%0b required 1/1/0",
                     ready_a, ready_b, vout_a);
        end
    endtask

    task automatic test_basic();
        push_a(16'd1);
        push_a(16'd2);
        push_a(16'd3);
        push_a(16'd4);
        valid_a = 1'b0;
        // One cycle after accepting element N: still in CALC
        checks++;
        if (vout_a !== 1'b0 || ready_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_calc_cycle: valid_out=%0b in_ready=%0b required 0/0",
                     vout_a, ready_a);
        end
        @(negedge clk);
        checks++;
        if (vout_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: valid_out=%0b required 1", vout_a);
        end
        checks++;
        if (mean_a !== 16'd2 || var_a !== 32'd3) begin
            errors++;
            $display("FAIL basic_1234: mean=%0d var=%0d required 2/3", $signed(mean_a), var_a);
        end
        handshake_a();
        checks++;
        if (ready_a !== 1'b1 || vout_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: in_ready=%0b valid_out=%0b required 1/0",
                     ready_a, vout_a);
        end
    endtask

    task automatic test_negative_const();
        push_a(16'hFFFB);
        push_a(16'hFFFB);
        push_a(16'hFFFB);
        push_a(16'hFFFB);
        valid_a = 1'b0;
        wait_out_a();
        checks++;
        if (mean_a !== 16'hFFFB || var_a !== 32'd0) begin
            errors++;
            $display("FAIL neg5_row: mean=%h var=%0d required fffb/0", mean_a, var_a);
        end
        handshake_a();
    endtask

    task automatic test_clamp();
        push_a(16'hFFFF);
        push_a(16'd0);
        push_a(16'd0);
        push_a(16'd0);
        valid_a = 1'b0;
        wait_out_a();
        checks++;
        if (mean_a !== 16'hFFFF || var_a !== 32'd0) begin
            errors++;
            $display("FAIL clamp_row: mean=%h var=%0d required ffff/0", mean_a, var_a);
        end
        handshake_a();
    endtask

    task automatic test_stall();
        int bad = 0;
        push_a(16'd1);
        push_a(16'd2);
        push_a(16'd3);
        push_a(16'd4);
        // Keep offering junk while the result is held
        valid_a = 1'b1;
        data_a  = 32'h1234_7FFF;
        wait_out_a();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (vout_a !== 1'b1 || ready_a !== 1'b0 || mean_a !== 16'd2 || var_a !== 32'd3) begin
                errors++;
                bad++;
                $display("FAIL stall_hold_%0d: valid_out=%0b in_ready=%0b mean=%0d var=%0d required 1/0/2/3",
                         i, vout_a, ready_a, $signed(mean_a), var_a);
            end
            @(negedge clk);
        end
        // Handshake with junk still valid; it must not be counted
        oready_a = 1'b1;
        @(negedge clk);
        oready_a = 1'b0;
        valid_a  = 1'b0;
        push_a(16'd2);
        push_a(16'd4);
        push_a(16'd6);
        push_a(16'd8);
        valid_a = 1'b0;
        wait_out_a();
        checks++;
        if (mean_a !== 16'd5 || var_a !== 32'd5) begin
            errors++;
            $display("FAIL stall_next_row: mean=%0d var=%0d required 5/5", $signed(mean_a), var_a);
        end
        handshake_a();
    endtask

    task automatic test_back_to_back();
        push_a(16'd1);
        push_a(16'd2);
        push_a(16'd3);
        push_a(16'd4);
        valid_a = 1'b0;
        wait_out_a();
        // First element of the next row offered together with the handshake
        oready_a = 1'b1;
        valid_a  = 1'b1;
        data_a   = {16'h0000, 16'hFFFC};
        @(negedge clk);
        oready_a = 1'b0;
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_hs: in_ready=%0b required 1", ready_a);
        end
        @(negedge clk);
        push_a(16'hFFFE);
        push_a(16'd2);
        push_a(16'd8);
        valid_a = 1'b0;
        wait_out_a();
        checks++;
        if (mean_a !== 16'd1 || var_a !== 32'd21) begin
            errors++;
            $display("FAIL b2b_row: mean=%0d var=%0d required 1/21", $signed(mean_a), var_a);
        end
        handshake_a();
    endtask

    task automatic test_reset_mid_row();
        push_a(16'd7);
        push_a(16'd9);
        valid_a = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (vout_a !== 1'b0 || mean_a !== 16'h0000 || var_a !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid_out=%0b mean=%h var=%0d required 0/0000/0",
                     vout_a, mean_a, var_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        push_a(16'd10);
        push_a(16'd20);
        push_a(16'd30);
        push_a(16'd40);
        valid_a = 1'b0;
        wait_out_a();
        checks++;
        if (mean_a !== 16'd25 || var_a !== 32'd125) begin
            errors++;
            $display("FAIL reset_mid_row: mean=%0d var=%0d required 25/125", $signed(mean_a), var_a);
        end
        handshake_a();
    endtask

    task automatic test_full_scale();
        int guard = 0;
        for (int i = 0; i < 64; i++) begin
            push_b(16'h8000);
        end
        valid_b = 1'b0;
        while (!vout_b && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (vout_b !== 1'b1 || mean_b !== 16'h8000 || var_b !== 32'd0) begin
            errors++;
            $display("FAIL full_scale_row: valid_out=%0b mean=%h var=%0d required 1/8000/0",
                     vout_b, mean_b, var_b);
        end
        oready_b = 1'b1;
        @(negedge clk);
        oready_b = 1'b0;
        checks++;
        if (ready_b !== 1'b1 || vout_b !== 1'b0) begin
            errors++;
            $display("FAIL full_scale_release: in_ready=%0b valid_out=%0b required 1/0",
                     ready_b, vout_b);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_a  = 1'b0;
        data_a   = 32'd0;
        oready_a = 1'b0;
        valid_b  = 1'b0;
        data_b   = 32'd0;
        oready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_negative_const();
        test_clamp();
        test_stall();
        test_back_to_back();
        test_reset_mid_row();
        test_full_scale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_layernorm_stats
